// File: rtl/ifetch_unit.sv
// Multicycle instruction fetch stage: owns the PC, fetches one word at a time over a
// req/ack memory port, hands it to decode with valid/ready and resolves beq/bne via ALU zero.
module ifetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        alu_resolve,
    input  logic        alu_zero
);

    // Handshake: a word transfers to decode on any rising edge where instr_valid and
    // instr_ready are both high; instr/pc_out stay frozen while valid is high and ready low.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        RESOLVE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic [31:0] pc_out_next;
    logic        is_branch;
    logic [31:0] branch_offset;

    // beq (000100) and bne (000101) differ only in opcode bit 26.
    assign is_branch     = (instr[31:27] == 5'b00010);
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= PC_RESET;
            instr  <= 32'h0;
            pc_out <= 32'h0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            instr  <= instr_next;
            pc_out <= pc_out_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        instr_next  = instr;
        pc_out_next = pc_out;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_next  = imem_rdata;
                    pc_out_next = pc;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    if (is_branch) begin
                        state_next = RESOLVE;
                    end else begin
                        pc_next    = pc + 32'd4;
                        state_next = FETCH;
                    end
                end
            end
            RESOLVE: begin
                // pc still points at the branch itself here, so both paths add 4.
                if (alu_resolve) begin
                    pc_next    = alu_zero ? (pc + 32'd4 + branch_offset) : (pc + 32'd4);
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == HOLD);
    assign imem_addr   = pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: transaction-level reference model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_ready = 1'b0;
    logic        alu_resolve = 1'b0;
    logic        alu_zero = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_valid;

    logic        w_ack = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic        w_ready = 1'b0;
    logic        w_resolve = 1'b0;
    logic        w_zero = 1'b0;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_pc_out;
    logic        w_valid;

    int checks = 0;
    int errors = 0;

    ifetch_unit #(.PC_RESET(32'h00000000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .alu_resolve(alu_resolve), .alu_zero(alu_zero)
    );

    ifetch_unit #(.PC_RESET(32'hFFFFFFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .instr(w_instr), .pc_out(w_pc_out), .instr_valid(w_valid), .instr_ready(w_ready),
        .alu_resolve(w_resolve), .alu_zero(w_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks which stage of the one-in-flight instruction the unit is in.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc_out = 32'h0;
    bit m_idle = 1'b1, m_fetch = 1'b0, m_hold = 1'b0, m_wait = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc_out = 32'h0;
            m_idle = 1'b1; m_fetch = 1'b0; m_hold = 1'b0; m_wait = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0; m_fetch = 1'b1;
        end else if (m_fetch && imem_ack) begin
            m_instr = imem_rdata; m_pc_out = m_pc;
            m_fetch = 1'b0; m_hold = 1'b1;
        end else if (m_hold && instr_ready) begin
            m_hold = 1'b0;
            if (m_instr[31:26] == 6'd4 || m_instr[31:26] == 6'd5) begin
                m_wait = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4; m_fetch = 1'b1;
            end
        end else if (m_wait && alu_resolve) begin
            m_pc = m_pc + 32'd4 + (alu_zero ? 32'($signed(m_instr[15:0]) * 4) : 32'd0);
            m_wait = 1'b0; m_fetch = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_imem_req", {31'h0, imem_req}, {31'h0, m_fetch});
            chk("cyc_instr_valid", {31'h0, instr_valid}, {31'h0, m_hold});
            chk("cyc_imem_addr", imem_addr, m_pc);
            chk("cyc_instr", instr, m_instr);
            chk("cyc_pc_out", pc_out, m_pc_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 50) begin step(); n++; end
        if (!imem_req) begin
            checks++; errors++;
            $display("FAIL timeout_req: imem_req never rose at %0t", $time);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 50) begin step(); n++; end
        if (!instr_valid) begin
            checks++; errors++;
            $display("FAIL timeout_valid: instr_valid never rose at %0t", $time);
        end
    endtask

    // ALU resolve pulses during the wait cycles must be ignored while fetching.
    task automatic fetch(input logic [31:0] word, input int lat);
        wait_req();
        for (int i = 0; i < lat; i++) begin
            imem_ack = 1'b0; imem_rdata = $urandom;
            alu_resolve = 1'b1; alu_zero = 1'($urandom_range(0, 1));
            step();
        end
        alu_resolve = 1'b0;
        imem_ack = 1'b1; imem_rdata = word;
        step();
        imem_ack = 1'b0; imem_rdata = $urandom;
    endtask

    // Stray acks and resolves while holding must not disturb the held word.
    task automatic consume(input int stall);
        wait_valid();
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            imem_ack = 1'b1; imem_rdata = $urandom;
            alu_resolve = 1'b1; alu_zero = 1'b1;
            step();
        end
        imem_ack = 1'b0; alu_resolve = 1'b0;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    task automatic resolve(input logic zero, input int delay);
        for (int i = 0; i < delay; i++) begin
            alu_resolve = 1'b0; alu_zero = 1'($urandom_range(0, 1));
            step();
        end
        alu_resolve = 1'b1; alu_zero = zero;
        step();
        alu_resolve = 1'b0; alu_zero = 1'b0;
    endtask

    task automatic expect_req(input string name, input logic [31:0] addr);
        wait_req();
        chk(name, imem_addr, addr);
    endtask

    initial begin
        // Reset asserted mid-cycle: outputs take reset values immediately.
        #2 rst = 1'b1;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("wrap_rst_addr", w_addr, 32'hFFFFFFFC);
        chk("wrap_rst_req", {31'h0, w_req}, 32'h0);
        step(); step();
        #2 rst = 1'b0;
        #1;
        chk("idle_req", {31'h0, imem_req}, 32'h0);
        step();
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);

        // Sequential: ack in the first FETCH cycle, immediate acceptance.
        imem_ack = 1'b1; imem_rdata = 32'h24010005;
        step();
        imem_ack = 1'b0;
        chk("seq_valid", {31'h0, instr_valid}, 32'h1);
        chk("seq_instr", instr, 32'h24010005);
        chk("seq_pc_out", pc_out, 32'h0);
        chk("seq_req_low", {31'h0, imem_req}, 32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("seq_next_req", {31'h0, imem_req}, 32'h1);
        chk("seq_next_addr", imem_addr, 32'h4);

        // Backpressure for 3 cycles.
        fetch(32'h24020007, 2);
        consume(3);
        expect_req("bp_next_addr", 32'h8);

        // Branches.
        fetch(32'h10000003, 1); consume(1); resolve(1'b1, 2);
        expect_req("beq_taken", 32'h18);
        fetch(32'h14000003, 0); consume(0); resolve(1'b0, 0);
        expect_req("bne_not_taken", 32'h1C);
        fetch(32'h1000FFFF, 0); consume(0); resolve(1'b1, 1);
        expect_req("beq_self", 32'h1C);
        fetch(32'h1000FFF7, 0); consume(0); resolve(1'b1, 0);
        expect_req("beq_back_to_top", 32'hFFFFFFFC);
        fetch(32'h24010001, 2); consume(0);
        expect_req("pc_wrap", 32'h0);
        fetch(32'h14000002, 0); consume(0); resolve(1'b1, 0);
        expect_req("bne_taken", 32'hC);
        fetch(32'h10000005, 0); consume(2); resolve(1'b0, 3);
        expect_req("beq_not_taken", 32'h10);

        // Mid-fetch reset with a late ack.
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        step(); step();
        #2 rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        chk("mid_idle_req", {31'h0, imem_req}, 32'h0);
        step();
        imem_ack = 1'b0;
        chk("late_ack_valid", {31'h0, instr_valid}, 32'h0);
        chk("restart_req", {31'h0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        fetch(32'h24030003, 0); consume(0);
        expect_req("restart_next", 32'h4);

        // Non-zero reset PC wrapping on the first sequential step.
        chk("wrap_req", {31'h0, w_req}, 32'h1);
        chk("wrap_addr", w_addr, 32'hFFFFFFFC);
        w_ack = 1'b1; w_rdata = 32'h24040004;
        step();
        w_ack = 1'b0;
        chk("wrap_valid", {31'h0, w_valid}, 32'h1);
        chk("wrap_instr", w_instr, 32'h24040004);
        chk("wrap_pc_out", w_pc_out, 32'hFFFFFFFC);
        w_ready = 1'b1;
        step();
        w_ready = 1'b0;
        chk("wrap_next_req", {31'h0, w_req}, 32'h1);
        chk("wrap_next_addr", w_addr, 32'h0);

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
